// File: rtl/keypad_event_scan.sv
// 3x4 keypad scanner: drives columns, samples rows, debounces per frame, emits one event per press.
// Optional auto-repeat of key_valid while a key stays held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_event_scan #(
   parameter int unsigned SCAN_DIV            = 1000,
   parameter int unsigned DEBOUNCE_FRAMES     = 4,
   parameter int unsigned REPEAT_DELAY_FRAMES = 64,
   parameter int unsigned REPEAT_RATE_FRAMES  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  key_row,
   output logic [2:0]  key_col,
   output logic        key_valid,
   output logic [3:0]  key_code,
   output logic [11:0] key_onehot,
   output logic        key_held
);

   localparam int unsigned DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam logic [3:0]  KEY_NONE = 4'hF;

   if (SCAN_DIV < 2 || DEBOUNCE_FRAMES < 1 || REPEAT_DELAY_FRAMES < 1 || REPEAT_RATE_FRAMES < 1)
   begin : g_bad_params
      $error("keypad_event_scan: illegal parameter set");
   end

   typedef enum logic [2:0] {COL0 = 3'b001, COL1 = 3'b010, COL2 = 3'b100} col_e;

   col_e          col_q, col_d;
   logic [1:0]    col_idx;
   logic [DW-1:0] dwell_q;
   logic          sample_c, frame_end_c;
   logic [2:0]    row_cnt, hits_sum;
   logic [1:0]    row_sel;
   logic [3:0]    cur_idx, frame_res;
   logic [1:0]    acc_hits_q;
   logic [3:0]    acc_idx_q;
   logic [3:0]    cand_q, cand_d, stable_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept_c, repeat_c;

   // Column dwell timer; rows settle for SCAN_DIV-1 cycles before sampling.
   assign sample_c    = (dwell_q == DW'(SCAN_DIV - 1));
   assign frame_end_c = sample_c && (col_q == COL2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          dwell_q <= '0;
      else if (sample_c) dwell_q <= '0;
      else               dwell_q <= dwell_q + DW'(1);
   end

   // Column scan FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) col_q <= COL0;
      else      col_q <= col_d;
   end

   // Column scan FSM: next state
   always_comb begin
      col_d = col_q;
      if (sample_c) begin
         case (col_q)
            COL0:    col_d = COL1;
            COL1:    col_d = COL2;
            default: col_d = COL0;
         endcase
      end
   end

   // Column scan FSM: outputs
   always_comb begin
      key_col = col_q;
      case (col_q)
         COL1:    col_idx = 2'd1;
         COL2:    col_idx = 2'd2;
         default: col_idx = 2'd0;
      endcase
   end

   // Row decode of the current sample and merge with earlier samples of the frame.
   always_comb begin
      row_cnt = 3'(key_row[0]) + 3'(key_row[1]) + 3'(key_row[2]) + 3'(key_row[3]);
      row_sel = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (key_row[r]) row_sel = 2'(r);
      end
      cur_idx  = 4'(row_sel) * 4'd3 + 4'(col_idx);
      hits_sum = 3'(acc_hits_q) + row_cnt;
      if (hits_sum == 3'd1) frame_res = (acc_hits_q == 2'd1) ? acc_idx_q : cur_idx;
      else                  frame_res = KEY_NONE;
   end

   // Hit accumulator saturates at 2: anything beyond one closed contact is ghosting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_hits_q <= '0;
         acc_idx_q  <= '0;
      end else if (frame_end_c) begin
         acc_hits_q <= '0;
         acc_idx_q  <= '0;
      end else if (sample_c) begin
         acc_hits_q <= (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
         if (acc_hits_q == 2'd0) acc_idx_q <= cur_idx;
      end
   end

   // Frame-level debounce: candidate must repeat DEBOUNCE_FRAMES times to become stable.
   always_comb begin
      cand_d = cand_q;
      cnt_d  = cnt_q;
      if (frame_res == cand_q) begin
         if (cnt_q != CW'(DEBOUNCE_FRAMES)) cnt_d = cnt_q + CW'(1);
      end else begin
         cand_d = frame_res;
         cnt_d  = CW'(1);
      end
      accept_c = frame_end_c && (cnt_d == CW'(DEBOUNCE_FRAMES)) && (cand_d != stable_q);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand_q   <= KEY_NONE;
         cnt_q    <= '0;
         stable_q <= KEY_NONE;
      end else if (frame_end_c) begin
         cand_q <= cand_d;
         cnt_q  <= cnt_d;
         if (accept_c) stable_q <= cand_d;
      end
   end

`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned REP_MAX = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ?
                                     REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
   localparam int unsigned RW = $clog2(REP_MAX + 1);

   logic [RW-1:0] rep_cnt_q, rep_cnt_n;
   logic          rep_phase_q;

   // Held-frame counter: first threshold is the delay, later ones the rate.
   always_comb begin
      rep_cnt_n = rep_cnt_q + RW'(1);
      repeat_c  = frame_end_c && !accept_c && (stable_q != KEY_NONE) &&
                  (rep_cnt_n == (rep_phase_q ? RW'(REPEAT_RATE_FRAMES) : RW'(REPEAT_DELAY_FRAMES)));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b0;
      end else if (accept_c) begin
         rep_cnt_q   <= '0;
         rep_phase_q <= 1'b0;
      end else if (frame_end_c && (stable_q != KEY_NONE)) begin
         if (repeat_c) begin
            rep_cnt_q   <= '0;
            rep_phase_q <= 1'b1;
         end else begin
            rep_cnt_q <= rep_cnt_n;
         end
      end
   end
`else
   assign repeat_c = 1'b0;
`endif

   // Event outputs; a release clears held/onehot but keeps the last code.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_valid  <= 1'b0;
         key_code   <= '0;
         key_onehot <= '0;
         key_held   <= 1'b0;
      end else begin
         key_valid <= (accept_c && (cand_d != KEY_NONE)) || repeat_c;
         if (accept_c) begin
            if (cand_d != KEY_NONE) begin
               key_code   <= cand_d;
               key_onehot <= 12'(1) << cand_d;
               key_held   <= 1'b1;
            end else begin
               key_onehot <= '0;
               key_held   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_keypad_event_scan.sv
// Directed bench for keypad_event_scan with SCAN_DIV=4, DEBOUNCE_FRAMES=3 (12-cycle frames).
// Repeat scenario is compiled in only when KEYPAD_REPEAT_EN is defined.
`timescale 1ns/1ps
module tb_keypad_event_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  key_row;
   logic [2:0]  key_col;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [11:0] key_onehot;
   logic        key_held;

   logic [11:0] pressed;
   logic        prev_valid;
   int          nvec, nerr, cyc, pulses, last_pulse;
   int          pulse_q[$];

   always #5 clk = ~clk;

   keypad_event_scan #(
      .SCAN_DIV(4), .DEBOUNCE_FRAMES(3), .REPEAT_DELAY_FRAMES(5), .REPEAT_RATE_FRAMES(2)
   ) dut (
      .clk(clk), .rst(rst), .key_row(key_row), .key_col(key_col),
      .key_valid(key_valid), .key_code(key_code), .key_onehot(key_onehot), .key_held(key_held)
   );

   // Keypad matrix: a row reads 1 when a pressed key sits in the driven column.
   always_comb begin
      key_row = 4'b0000;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 3; c++)
            if (key_col[c] && pressed[r*3+c]) key_row[r] = 1'b1;
   end

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (key_valid) begin
            nvec++;
            if (prev_valid) begin
               nerr++;
               $display("FAIL single_cycle_valid: key_valid high on cycles %0d and %0d, required one cycle", cyc - 1, cyc);
            end
            pulses++;
            last_pulse = cyc;
            pulse_q.push_back(cyc);
         end
         prev_valid = key_valid;
      end
   endtask

   task automatic do_reset(input logic [11:0] keys);
      @(negedge clk);
      rst = 1'b0;
      pressed = keys;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      cyc = 0; pulses = 0; last_pulse = -1; prev_valid = 1'b0;
      pulse_q.delete();
   endtask

   task automatic test_reset();
      do_reset(12'h010);
      run(45);
      nvec++;
      if (key_held !== 1'b1) begin nerr++; $display("FAIL pre_reset_held: got %b, want 1", key_held); end
      rst = 1'b0;
      #1;
      nvec++;
      if (key_col !== 3'b001) begin nerr++; $display("FAIL reset_col: got %b, want 001", key_col); end
      nvec++;
      if (key_valid !== 1'b0 || key_held !== 1'b0) begin
         nerr++; $display("FAIL reset_flags: valid=%b held=%b, want 0 0", key_valid, key_held);
      end
      nvec++;
      if (key_code !== 4'd0 || key_onehot !== 12'h000) begin
         nerr++; $display("FAIL reset_code: code=%0d onehot=%h, want 0 000", key_code, key_onehot);
      end
      pressed = '0;
      @(negedge clk);
      rst = 1'b1;
      cyc = 0; pulses = 0; prev_valid = 1'b0;
      run(3);
      nvec++;
      if (key_col !== 3'b001) begin nerr++; $display("FAIL col_dwell: got %b at cycle 3, want 001", key_col); end
      run(1);
      nvec++;
      if (key_col !== 3'b010) begin nerr++; $display("FAIL col_rotate: got %b at cycle 4, want 010", key_col); end
      run(8);
      nvec++;
      if (key_col !== 3'b001) begin nerr++; $display("FAIL col_wrap: got %b at cycle 12, want 001", key_col); end
   endtask

   task automatic test_press();
      do_reset(12'h010);
      run(35);
      nvec++;
      if (pulses !== 0 || key_held !== 1'b0) begin
         nerr++; $display("FAIL press_early: pulses=%0d held=%b at cycle 35, want 0 0", pulses, key_held);
      end
      run(1);
      nvec++;
      if (pulses !== 1 || last_pulse !== 36) begin
         nerr++; $display("FAIL press_latency: pulses=%0d last=%0d, want 1 at cycle 36", pulses, last_pulse);
      end
      nvec++;
      if (key_code !== 4'd4 || key_onehot !== 12'h010 || key_held !== 1'b1) begin
         nerr++; $display("FAIL press_outputs: code=%0d onehot=%h held=%b, want 4 010 1", key_code, key_onehot, key_held);
      end
      run(240);
`ifndef KEYPAD_REPEAT_EN
      nvec++;
      if (pulses !== 1) begin nerr++; $display("FAIL no_repeat: pulses=%0d over hold, want 1", pulses); end
`endif
   endtask

   task automatic test_release_switch();
      pulses = 0;
      pressed = '0;
      run(35);
      nvec++;
      if (key_held !== 1'b1) begin nerr++; $display("FAIL release_early: held=%b at cycle %0d, want 1", key_held, cyc); end
      run(1);
      nvec++;
      if (key_held !== 1'b0 || key_onehot !== 12'h000 || key_code !== 4'd4 || pulses !== 0) begin
         nerr++; $display("FAIL release: held=%b onehot=%h code=%0d pulses=%0d, want 0 000 4 0",
                          key_held, key_onehot, key_code, pulses);
      end
      pressed = 12'h010;
      run(36);
      nvec++;
      if (pulses !== 1 || last_pulse !== cyc || key_code !== 4'd4) begin
         nerr++; $display("FAIL repress: pulses=%0d last=%0d code=%0d, want 1 at %0d code 4", pulses, last_pulse, key_code, cyc);
      end
      pressed = 12'h400;
      pulses = 0;
      run(36);
      nvec++;
      if (pulses !== 1 || last_pulse !== cyc) begin
         nerr++; $display("FAIL switch_pulse: pulses=%0d last=%0d, want 1 at %0d", pulses, last_pulse, cyc);
      end
      nvec++;
      if (key_code !== 4'd10 || key_onehot !== 12'h400 || key_held !== 1'b1) begin
         nerr++; $display("FAIL switch_outputs: code=%0d onehot=%h held=%b, want 10 400 1", key_code, key_onehot, key_held);
      end
   endtask

   task automatic test_glitch();
      do_reset(12'h800);
      run(24);
      pressed = '0;
      run(36);
      nvec++;
      if (pulses !== 0 || key_held !== 1'b0) begin
         nerr++; $display("FAIL glitch: pulses=%0d held=%b, want 0 0", pulses, key_held);
      end
      pressed = 12'h800;
      run(36);
      nvec++;
      if (pulses !== 1 || last_pulse !== 96) begin
         nerr++; $display("FAIL hash_pulse: pulses=%0d last=%0d, want 1 at 96", pulses, last_pulse);
      end
      nvec++;
      if (key_code !== 4'd11 || key_onehot !== 12'h800) begin
         nerr++; $display("FAIL hash_code: code=%0d onehot=%h, want 11 800", key_code, key_onehot);
      end
   endtask

   task automatic test_multi();
      do_reset(12'h003);
      run(60);
      nvec++;
      if (pulses !== 0 || key_held !== 1'b0) begin
         nerr++; $display("FAIL multi_press: pulses=%0d held=%b, want 0 0", pulses, key_held);
      end
      pressed = 12'h001;
      run(36);
      nvec++;
      if (pulses !== 1 || last_pulse !== 96) begin
         nerr++; $display("FAIL multi_release: pulses=%0d last=%0d, want 1 at 96", pulses, last_pulse);
      end
      nvec++;
      if (key_code !== 4'd0 || key_onehot !== 12'h001 || key_held !== 1'b1) begin
         nerr++; $display("FAIL multi_code: code=%0d onehot=%h held=%b, want 0 001 1", key_code, key_onehot, key_held);
      end
   endtask

`ifdef KEYPAD_REPEAT_EN
   task automatic test_repeat();
      do_reset(12'h010);
      run(150);
      nvec++;
      if (pulse_q.size() !== 4) begin
         nerr++; $display("FAIL repeat_count: got %0d pulses, want 4", pulse_q.size());
      end else begin
         nvec++;
         if (pulse_q[0] !== 36 || pulse_q[1] !== 96 || pulse_q[2] !== 120 || pulse_q[3] !== 144) begin
            nerr++; $display("FAIL repeat_times: got %0d %0d %0d %0d, want 36 96 120 144",
                             pulse_q[0], pulse_q[1], pulse_q[2], pulse_q[3]);
         end
      end
      nvec++;
      if (key_code !== 4'd4) begin nerr++; $display("FAIL repeat_code: got %0d, want 4", key_code); end
      pressed = '0;
      run(30);
      nvec++;
      if (key_held !== 1'b0) begin nerr++; $display("FAIL repeat_release: held=%b, want 0", key_held); end
      pulse_q.delete();
      run(120);
      nvec++;
      if (pulse_q.size() !== 0) begin
         nerr++; $display("FAIL repeat_stop: got %0d pulses after release, want 0", pulse_q.size());
      end
   endtask
`endif

   initial begin
      nvec = 0; nerr = 0; cyc = 0; pulses = 0; last_pulse = -1;
      prev_valid = 1'b0;
      pressed = '0;
      rst = 1'b0;
      test_reset();
      test_press();
      test_release_switch();
      test_glitch();
      test_multi();
`ifdef KEYPAD_REPEAT_EN
      test_repeat();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/keypad_event_scan.md
Name: keypad_event_scan

Overview:
- Upstream stage of the tic-tac-toe top: drives the 3 keypad columns, samples the 4 rows, debounces, and emits one clean event per key press.
- Output feeds the game controller, which places stones and starts the game from the main screen.
- Replaces a raw level-style key_data with a single-cycle event plus a held flag.

Parameters:
SCAN_DIV, 1000, clock cycles each column stays driven; sizes the column dwell counter; must be >= 2.
DEBOUNCE_FRAMES, 4, consecutive identical scan frames needed to accept a press or release; must be >= 1.
REPEAT_DELAY_FRAMES, 64, frames a key is held before the first auto-repeat (KEYPAD_REPEAT_EN only).
REPEAT_RATE_FRAMES, 16, frames between later auto-repeats (KEYPAD_REPEAT_EN only).

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-low reset
key_row  input  4  keypad row sense; 1 = key closed in the driven column
key_col  output  3  keypad column drive; one-hot, active-high
key_valid  output  1  single-cycle pulse per accepted press (and per repeat)
key_code  output  4  accepted key index 0..11; held until the next event
key_onehot  output  12  one-hot of key_code; all zero while no key is stable
key_held  output  1  1 while the debounced state is a key

Behaviour:
- Reset (rst=0, asynchronous): key_col=3'b001, dwell/frame/debounce counters=0, candidate=NONE, stable=NONE, key_valid=0, key_code=0, key_onehot=0, key_held=0. Scanning restarts cleanly when rst deasserts mid-frame.
- Key index = row*3 + col, with col 0..2 and row 0..3. Index 0..8 = keys 1..9, 9='*', 10='0', 11='#'.
- Column scan:
  - Dwell counter counts 0..SCAN_DIV-1.
  - Rows are sampled only on the cycle where dwell = SCAN_DIV-1 (settle time).
  - key_col then rotates 001 -> 010 -> 100 -> 001.
  - One frame = 3 dwells = 3*SCAN_DIV cycles.
- Frame result, computed on the last sample of the frame:
  - Exactly one row bit set across all 3 samples -> that index.
  - Zero bits -> NONE.
  - Two or more bits (multi-press, ghosting) -> NONE.
- Debounce, evaluated at frame end:
  - result == candidate -> count++, saturating at DEBOUNCE_FRAMES.
  - Otherwise candidate = result and count = 1.
  - When count == DEBOUNCE_FRAMES and candidate != stable, stable is set to candidate.
- Outputs on a stable change:
  - NONE -> key K, or key A -> key B: key_valid=1 for exactly one cycle, the cycle after the frame-end cycle. key_code=K and key_onehot=1<<K are updated in that same cycle; key_held=1.
  - Key -> NONE (release): no pulse. key_held=0, key_onehot=0. key_code keeps its last value.
- Latency: a bounce-free press that begins before frame F's column sample pulses key_valid 1 cycle after frame F+DEBOUNCE_FRAMES-1 ends.
- A glitch shorter than DEBOUNCE_FRAMES frames never changes stable.
- key_valid is never high on two consecutive cycles.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - While stable is a key, a frame counter runs.
  - key_valid re-pulses with the same key_code after REPEAT_DELAY_FRAMES frames of holding.
  - It then re-pulses every REPEAT_RATE_FRAMES frames.
  - The counter clears on any stable change and on reset.
- Undefined: the repeat logic is absent. Exactly one pulse per press; the REPEAT_* parameters are ignored.

Test Plan (SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame=12 cycles):
1. Assert rst=0 mid-frame, then release -> key_col=001, all outputs 0. key_col reaches 010 exactly 4 cycles after release.
2. Hold row1 high whenever col=010 (key index 4, keypad '5') -> key_valid pulses once, 1 cycle after the 3rd frame end. key_code=4, key_onehot=12'h010, key_held=1, with no further pulses over 20 frames (macro undefined).
3. Press '#' (row3, col 100) for 2 frames, then release -> no key_valid and key_held stays 0. A later 3-frame press gives one pulse with key_code=11.
4. Keys 1 and 2 held together (row0 during col 001 and col 010) -> no pulse. Releasing key 2 -> one pulse with key_code=0 after 3 frames.
5. Release after test 2 -> key_held=0 and key_onehot=0 after 3 frames, no pulse, key_code stays 4. Direct switch from '5' to '0' -> one pulse with key_code=10.
6. KEYPAD_REPEAT_EN with REPEAT_DELAY_FRAMES=5 and REPEAT_RATE_FRAMES=2, hold '5' -> pulses at the accept frame, then +5, +7, +9 frames. Release stops the pulses.
